// File: rtl/snake_pkg.sv
// Shared constants for the snake renderer: geometry, RGB565 colours and the
// game-state encoding used by the snake game logic.
package snake_pkg;
  localparam int MAX_LEN = 14;
  localparam int BLOCK_W = 20;
  localparam int SIDE_W  = 20;
  localparam int H_DISP  = 640;
  localparam int V_DISP  = 480;

  localparam logic [15:0] COL_HEAD = 16'hFFE0;
  localparam logic [15:0] COL_BODY = 16'h07E0;
  localparam logic [15:0] COL_FOOD = 16'hF800;
  localparam logic [15:0] COL_WALL = 16'h7BEF;
  localparam logic [15:0] COL_GRID = 16'h2104;
  localparam logic [15:0] COL_DEAD = 16'h8410;
  localparam logic [15:0] COL_BG   = 16'h0000;

  localparam logic [9:0] RST_HEAD_XY = 10'd100;
  localparam logic [9:0] RST_FOOD_XY = 10'd200;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DIE  = 2'd2
  } snake_state_e;
endpackage

// File: rtl/snake_block_hit.sv
// Square block hit test; 11-bit compares so bx+BLOCK_W never wraps.
module snake_block_hit #(
  parameter int BLOCK_W = snake_pkg::BLOCK_W
) (
  input  logic       en_i,
  input  logic [9:0] bx_i,
  input  logic [9:0] by_i,
  input  logic [9:0] px_i,
  input  logic [9:0] py_i,
  output logic       hit_o
);
  logic [10:0] px, py, bx, by;

  assign px = {1'b0, px_i};
  assign py = {1'b0, py_i};
  assign bx = {1'b0, bx_i};
  assign by = {1'b0, by_i};

  assign hit_o = en_i && (px >= bx) && (px < bx + 11'(BLOCK_W))
                      && (py >= by) && (py < by + 11'(BLOCK_W));
endmodule

// File: rtl/snake_render.sv
// Two-stage snake/food/wall pixel renderer working from a per-frame shadow copy.
// Optional background grid enabled by defining SNAKE_RENDER_GRID_EN.
module snake_render import snake_pkg::*; #(
  parameter int MAX_LEN = snake_pkg::MAX_LEN,
  parameter int BLOCK_W = snake_pkg::BLOCK_W,
  parameter int SIDE_W  = snake_pkg::SIDE_W,
  parameter int H_DISP  = snake_pkg::H_DISP,
  parameter int V_DISP  = snake_pkg::V_DISP
) (
  input  logic                  vga_clk,
  input  logic                  sys_rst_n,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [9:0]            pix_x,
  input  logic [9:0]            pix_y,
  input  logic [MAX_LEN*10-1:0] snake_x_flat,
  input  logic [MAX_LEN*10-1:0] snake_y_flat,
  input  logic [12:0]           snake_cur_len,
  input  logic [9:0]            food_x,
  input  logic [9:0]            food_y,
  input  logic                  die,
  output logic                  pix_de,
  output logic [15:0]           pix_data
);
  localparam int LW     = $clog2(MAX_LEN + 1);
  localparam int STAGES = 2;

  logic [MAX_LEN-1:0][9:0] sx_q, sy_q;
  logic [LW-1:0]           len_q, len_d;
  logic [9:0]              fx_q, fy_q;
  logic                    die_q;

  logic [MAX_LEN-1:0] seg_hit, seg_hit_q;
  logic               food_hit, food_q, wall_hit, wall_q, die1_q, grid_hit, grid_q;
  logic [STAGES:1]    vld_pipe;
  logic [15:0]        col_d, data_q;

  always_comb begin
    len_d = snake_cur_len[LW-1:0];
    if (snake_cur_len == 13'd0)               len_d = LW'(1);
    else if (snake_cur_len > 13'(MAX_LEN))    len_d = LW'(MAX_LEN);
  end

  // Shadow copy: game state only changes under the renderer at frame_start.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      sx_q[0] <= RST_HEAD_XY;
      sy_q[0] <= RST_HEAD_XY;
      len_q   <= LW'(1);
      fx_q    <= RST_FOOD_XY;
      fy_q    <= RST_FOOD_XY;
      die_q   <= 1'b0;
    end else if (frame_start) begin
      sx_q  <= snake_x_flat;
      sy_q  <= snake_y_flat;
      len_q <= len_d;
      fx_q  <= food_x;
      fy_q  <= food_y;
      die_q <= die;
    end
  end

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    snake_block_hit #(.BLOCK_W(BLOCK_W)) u_hit (
      .en_i (len_q > LW'(i)),
      .bx_i (sx_q[i]),
      .by_i (sy_q[i]),
      .px_i (pix_x),
      .py_i (pix_y),
      .hit_o(seg_hit[i])
    );
  end

  snake_block_hit #(.BLOCK_W(BLOCK_W)) u_food (
    .en_i (!die_q),
    .bx_i (fx_q),
    .by_i (fy_q),
    .px_i (pix_x),
    .py_i (pix_y),
    .hit_o(food_hit)
  );

  assign wall_hit = ({1'b0, pix_x} <  11'(SIDE_W))          ||
                    ({1'b0, pix_x} >= 11'(H_DISP - SIDE_W)) ||
                    ({1'b0, pix_y} <  11'(SIDE_W))          ||
                    ({1'b0, pix_y} >= 11'(V_DISP - SIDE_W));

`ifdef SNAKE_RENDER_GRID_EN
  localparam int GW = $clog2(BLOCK_W);
  logic [GW-1:0] gx_q, gy_q, gx_cur, gy_cur;

  // Running cell offsets; assume a raster scan (x increments, rows advance at x==0).
  always_comb begin
    if (pix_x == 10'(SIDE_W))               gx_cur = '0;
    else if (gx_q == GW'(BLOCK_W - 1))      gx_cur = '0;
    else                                    gx_cur = gx_q + GW'(1);
    gy_cur = gy_q;
    if (pix_y == 10'(SIDE_W))               gy_cur = '0;
    else if (pix_x == 10'd0)                gy_cur = (gy_q == GW'(BLOCK_W - 1)) ? '0 : gy_q + GW'(1);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      gx_q <= '0;
      gy_q <= '0;
    end else if (pix_valid) begin
      gx_q <= gx_cur;
      gy_q <= gy_cur;
    end
  end

  assign grid_hit = !wall_hit && (gx_cur == '0 || gy_cur == '0);
`else
  assign grid_hit = 1'b0;
`endif

  // Stage 1 also carries die so in-flight pixels keep their pre-snapshot colour.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_hit_q <= '0;
      food_q    <= 1'b0;
      wall_q    <= 1'b0;
      grid_q    <= 1'b0;
      die1_q    <= 1'b0;
      vld_pipe  <= '0;
      data_q    <= COL_BG;
    end else begin
      seg_hit_q <= seg_hit;
      food_q    <= food_hit;
      wall_q    <= wall_hit;
      grid_q    <= grid_hit;
      die1_q    <= die_q;
      vld_pipe  <= {vld_pipe[STAGES-1:1], pix_valid};
      data_q    <= col_d;
    end
  end

  always_comb begin
    col_d = COL_BG;
    if (!vld_pipe[1])               col_d = COL_BG;
    else if (seg_hit_q[0])          col_d = die1_q ? COL_DEAD : COL_HEAD;
    else if (|seg_hit_q[MAX_LEN-1:1]) col_d = die1_q ? COL_DEAD : COL_BODY;
    else if (food_q)                col_d = COL_FOOD;
    else if (wall_q)                col_d = COL_WALL;
    else if (grid_q)                col_d = COL_GRID;
  end

  assign pix_de   = vld_pipe[STAGES];
  assign pix_data = data_q;
endmodule

// File: tb/tb_snake_render.sv
// Directed-vector bench for snake_render with a queue-based scoreboard.
module tb_snake_render;
  localparam int ML = 14;

  typedef struct {
    logic [15:0] d;
    int          cyc;
    int          x;
    int          y;
  } exp_t;

  logic              vga_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              pix_valid = 1'b0;
  logic              die = 1'b0;
  logic [9:0]        pix_x = '0, pix_y = '0;
  logic [9:0]        food_x = 10'd200, food_y = 10'd200;
  logic [ML*10-1:0]  snake_x_flat = '0, snake_y_flat = '0;
  logic [12:0]       snake_cur_len = 13'd1;
  logic              pix_de;
  logic [15:0]       pix_data;

  logic [9:0] sx[ML];
  logic [9:0] sy[ML];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  exp_t q[$];
  exp_t e_mon;

  snake_render dut (
    .vga_clk      (vga_clk),
    .sys_rst_n    (sys_rst_n),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .snake_x_flat (snake_x_flat),
    .snake_y_flat (snake_y_flat),
    .snake_cur_len(snake_cur_len),
    .food_x       (food_x),
    .food_y       (food_y),
    .die          (die),
    .pix_de       (pix_de),
    .pix_data     (pix_data)
  );

  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;

  // Monitor: pop an expectation for every valid output, check idle output is zero.
  always @(negedge vga_clk) begin
    if (pix_de === 1'b1) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_de got pix_data=%h want no output", pix_data);
      end else begin
        e_mon = q.pop_front();
        if (pix_data !== e_mon.d) begin
          nerr++;
          $display("FAIL pix(%0d,%0d) got %h want %h", e_mon.x, e_mon.y, pix_data, e_mon.d);
        end
        if (cyc - e_mon.cyc != 2) begin
          nerr++;
          $display("FAIL lat(%0d,%0d) got %0d want 2", e_mon.x, e_mon.y, cyc - e_mon.cyc);
        end
      end
    end else begin
      nvec++;
      if (pix_data !== 16'h0000 || pix_de !== 1'b0) begin
        nerr++;
        $display("FAIL idle_out got de=%b data=%h want de=0 data=0000", pix_de, pix_data);
      end
    end
  end

  task automatic pack();
    for (int i = 0; i < ML; i++) begin
      snake_x_flat[i*10 +: 10] = sx[i];
      snake_y_flat[i*10 +: 10] = sy[i];
    end
  endtask

  task automatic send(input int x, input int y, input logic [15:0] d, input logic fs = 1'b0);
    exp_t e;
    e.d = d; e.cyc = cyc; e.x = x; e.y = y;
    pix_valid   = 1'b1;
    pix_x       = 10'(x);
    pix_y       = 10'(y);
    frame_start = fs;
    q.push_back(e);
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge vga_clk); #1; end
  endtask

  task automatic snap();
    pack();
    frame_start = 1'b1;
    @(posedge vga_clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic chk_rst(input string nm);
    nvec++;
    if (pix_de !== 1'b0 || pix_data !== 16'h0000) begin
      nerr++;
      $display("FAIL %s got de=%b data=%h want de=0 data=0000", nm, pix_de, pix_data);
    end
  endtask

  initial begin
    int budget;
    for (int i = 0; i < ML; i++) begin sx[i] = '0; sy[i] = '0; end
    sx[0] = 10'd100; sy[0] = 10'd100;
    pack();
    #1;
    chk_rst("reset_t0");
    idle(3);
    chk_rst("reset_hold");
    sys_rst_n = 1'b1;
    idle(2);

    // Head only, plus food and walls
    snake_cur_len = 13'd1;
    snap();
    send(100, 100, 16'hFFE0);
    send(119, 119, 16'hFFE0);
    send(120, 100, 16'h0000);
    send( 99, 100, 16'h0000);
    send(205, 205, 16'hF800);
    send(  5,   5, 16'h7BEF);
    send(620, 100, 16'h7BEF);
    send(619, 100, 16'h0000);
    send(100, 460, 16'h7BEF);
    send(100, 459, 16'h0000);
    idle(3);

    // Three segments, food hidden under head
    sx[1] = 10'd80; sy[1] = 10'd100;
    sx[2] = 10'd60; sy[2] = 10'd100;
    food_x = 10'd100; food_y = 10'd100;
    snake_cur_len = 13'd3;
    snap();
    send(105, 105, 16'hFFE0);
    send( 85, 105, 16'h07E0);
    send( 65, 105, 16'h07E0);
    send( 45, 105, 16'h0000);
    idle(3);

    // Inputs change without frame_start: shadow must hold
    sx[0] = 10'd300; sy[0] = 10'd300;
    food_x = 10'd200; food_y = 10'd200;
    pack();
    send(105, 105, 16'hFFE0);
    send(305, 305, 16'h0000);
    idle(2);
    snap();
    send(105, 105, 16'h0000);
    send(305, 305, 16'hFFE0);
    send(205, 205, 16'hF800);
    idle(3);

    // Game over colouring
    sx[0] = 10'd100; sy[0] = 10'd100;
    die = 1'b1;
    snap();
    send(105, 105, 16'h8410);
    send( 85, 105, 16'h8410);
    send(205, 205, 16'h0000);
    send(  5,   5, 16'h7BEF);
    idle(3);

    // Length clamping and 11-bit compare at the right edge
    die = 1'b0;
    snake_cur_len = 13'd0;
    snap();
    send( 85, 105, 16'h0000);
    send(105, 105, 16'hFFE0);
    idle(2);
    sx[13] = 10'd400;  sy[13] = 10'd300;
    sx[12] = 10'd1010; sy[12] = 10'd100;
    snake_cur_len = 13'd20;
    snap();
    send( 405, 305, 16'h07E0);
    send(1015, 105, 16'h07E0);
    send(   5, 105, 16'h7BEF);
    idle(2);
    snake_cur_len = 13'd13;
    snap();
    send( 405, 305, 16'h0000);
    send(1015, 105, 16'h07E0);
    idle(3);

    // frame_start coincident with a valid pixel
    sx[0] = 10'd300; sy[0] = 10'd300;
    snake_cur_len = 13'd1;
    pack();
    send(105, 105, 16'hFFE0, 1'b1);
    send(105, 105, 16'h0000);
    send(305, 305, 16'hFFE0);
    die = 1'b1;
    send(305, 305, 16'hFFE0, 1'b1);
    send(305, 305, 16'h8410);
    idle(3);

    // Reset mid-line
    die = 1'b0;
    send(105, 105, 16'h0000);
    send(305, 305, 16'h8410);
    sys_rst_n = 1'b0;
    #1;
    chk_rst("reset_midline");
    q.delete();
    idle(2);
    chk_rst("reset_midline_hold");
    sys_rst_n = 1'b1;
    idle(1);
    send(105, 105, 16'hFFE0);
    send(205, 205, 16'hF800);
    send(125, 105, 16'h0000);
    send(305, 305, 16'h0000);

    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(posedge vga_clk); #1;
      budget++;
    end
    nvec++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
